seg_scan_mux: RTL and testbench

- Parametrised multi-digit seven-segment scan driver for board-level debug display (CPU register/PC readout).
- Time-multiplexes NUM_DIGITS hex nibbles onto one shared active-low segment bus and active-low anodes.
- Adds to the fixed 8-digit scanner:
  - programmable scan rate;
  - anti-ghosting blank interval;
  - frame-coherent data snapshot;
  - per-digit blank mask;
  - decimal points;
  - enable control;
  - frame-done strobe.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_mux.sv | 170 +++++++++++++++++
 tb/tb_seg_scan_mux.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and hex-to-segment table for the seven-segment scan driver
// and the other debug display paths.
package seg_pkg;

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Active-low segments ordered {a,b,c,d,e,f,g}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0001100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seg_scan_mux.sv
// Multi-digit seven-segment scan driver with blanking interval, frame-coherent
// shadow registers and per-digit masks. Optional macro: SEG_LZ_SUPPRESS_EN.
//
// state   | meaning
// S_IDLE  | display dark, waiting for enable
// S_BLANK | start of a digit slot, all anodes off (anti-ghosting)
// S_SHOW  | anode of current digit driven for the rest of the slot
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
    localparam scan_state_t SLOT_START = (BLANK_CYCLES == 0) ? S_SHOW : S_BLANK;

    scan_state_t             state, state_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [DIV_W-1:0]        div_cnt, div_nxt;
    logic [4*NUM_DIGITS-1:0] data_sh, data_sh_nxt;
    logic [NUM_DIGITS-1:0]   dp_sh, dp_sh_nxt;
    logic [NUM_DIGITS-1:0]   blank_sh, blank_sh_nxt;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic                    snap;
    logic                    fd_nxt;
    logic [3:0]              nib;
    logic                    cur_blank, cur_dp, visible;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;

`ifdef SEG_LZ_SUPPRESS_EN
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  lead;

    // Blank zero digits above the first nonzero one; digit 0 always shows.
    always_comb begin
        lz_mask = '0;
        lead    = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lead && (data[4*i +: 4] == 4'h0)) lz_mask[i] = 1'b1;
            else                                  lead       = 1'b0;
        end
    end

    assign snap_blank = blank_in | lz_mask;
`else
    assign snap_blank = blank_in;
`endif

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        div_nxt      = div_cnt;
        data_sh_nxt  = data_sh;
        dp_sh_nxt    = dp_sh;
        blank_sh_nxt = blank_sh;
        snap         = 1'b0;
        fd_nxt       = 1'b0;
        if (!enable) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
            div_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    snap      = 1'b1;
                    idx_nxt   = '0;
                    div_nxt   = '0;
                    state_nxt = SLOT_START;
                end
                default: begin
                    if (div_cnt == DIV_LAST) begin
                        div_nxt   = '0;
                        state_nxt = SLOT_START;
                        if (idx == IDX_LAST) begin
                            idx_nxt = '0;
                            snap    = 1'b1;
                            fd_nxt  = 1'b1;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end else begin
                        div_nxt = div_cnt + 1'b1;
                        if ((state == S_BLANK) && (div_nxt == BLANK_END)) state_nxt = S_SHOW;
                    end
                end
            endcase
        end
        if (snap) begin
            data_sh_nxt  = data;
            dp_sh_nxt    = dp_in;
            blank_sh_nxt = snap_blank;
        end
    end

    // Outputs are decoded from next-state values so they register on the same edge.
    always_comb begin
        nib       = 4'h0;
        cur_blank = 1'b1;
        cur_dp    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_nxt) begin
                nib       = data_sh_nxt[4*i +: 4];
                cur_blank = blank_sh_nxt[i];
                cur_dp    = dp_sh_nxt[i];
            end
        end
    end

    seg_hex_decode u_dec (
        .hex (nib),
        .seg (dec_seg)
    );

    always_comb begin
        visible = (state_nxt == S_SHOW) && !cur_blank;
        an_nxt  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (visible && (IDX_W'(i) == idx_nxt)) an_nxt[i] = 1'b0;
        end
        seg_nxt = visible ? dec_seg : SEG_OFF;
        dp_nxt  = visible ? ~cur_dp : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            div_cnt    <= '0;
            data_sh    <= '0;
            dp_sh      <= '0;
            blank_sh   <= '0;
            an         <= '1;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            div_cnt    <= div_nxt;
            data_sh    <= data_sh_nxt;
            dp_sh      <= dp_sh_nxt;
            blank_sh   <= blank_sh_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frame_done <= fd_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with 4 digits, 4-cycle slots, 1 blank cycle.
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    seg_scan_mux #(
        .NUM_DIGITS   (4),
        .CLK_DIV      (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .data       (data),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [15:0] d;
        logic [3:0]  dpi;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_dp;
        logic        exp_fd;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] d, input logic [3:0] a, input logic [6:0] s,
                       input logic p, input logic f);
        vec_t v;
        v.en = 1'b1; v.d = d; v.dpi = 4'b0010;
        v.exp_an = a; v.exp_seg = s; v.exp_dp = p; v.exp_fd = f;
        vecs.push_back(v);
    endtask

    initial begin
        int first1, first3, fd_cnt, fd_a, fd_b, an2_low, found, extra;

        rst = 1'b1; enable = 1'b0; data = 16'h0; dp_in = 4'h0; blank_in = 4'h0;
        tick();
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_seg", {9'h0, seg}, 16'h007F);
        chk("rst_dp", {15'h0, dp}, 16'h0001);
        chk("rst_fd", {15'h0, frame_done}, 16'h0000);
        rst = 1'b0;
        tick();

        // One full frame of 1234, data switched to ABCD in digit1 slot, then into frame 2.
        add(16'h1234, 4'hF, 7'h7F, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) add(16'h1234, 4'hE, 7'h4C, 1'b1, 1'b0);
        add(16'h1234, 4'hF, 7'h7F, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) add(16'hABCD, 4'hD, 7'h06, 1'b0, 1'b0);
        add(16'hABCD, 4'hF, 7'h7F, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) add(16'hABCD, 4'hB, 7'h12, 1'b1, 1'b0);
        add(16'hABCD, 4'hF, 7'h7F, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) add(16'hABCD, 4'h7, 7'h4F, 1'b1, 1'b0);
        add(16'hABCD, 4'hF, 7'h7F, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) add(16'hABCD, 4'hE, 7'h42, 1'b1, 1'b0);
        add(16'hABCD, 4'hF, 7'h7F, 1'b1, 1'b0);
        add(16'hABCD, 4'hD, 7'h31, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            enable = vecs[i].en; data = vecs[i].d; dp_in = vecs[i].dpi;
            tick();
            if (an !== vecs[i].exp_an || seg !== vecs[i].exp_seg ||
                dp !== vecs[i].exp_dp || frame_done !== vecs[i].exp_fd) begin
                $display("FAIL vec%0d actual an=%b seg=%b dp=%b fd=%b expected an=%b seg=%b dp=%b fd=%b",
                         i, an, seg, dp, frame_done, vecs[i].exp_an, vecs[i].exp_seg,
                         vecs[i].exp_dp, vecs[i].exp_fd);
                bad++;
            end
            total++;
        end

        // Blank mask: digit2 dark, slot timing and frame period unchanged.
        enable = 1'b0;
        tick();
        blank_in = 4'b0100; enable = 1'b1;
        first1 = -1; first3 = -1; fd_cnt = 0; fd_a = -1; fd_b = -1; an2_low = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (an[2] == 1'b0) an2_low++;
            if (an == 4'b1101 && first1 < 0) first1 = c;
            if (an == 4'b0111 && first3 < 0) first3 = c;
            if (frame_done) begin
                fd_cnt++;
                if (fd_a < 0) fd_a = c; else if (fd_b < 0) fd_b = c;
            end
        end
        chk("blank_an2_low", 16'(an2_low), 16'd0);
        chk("blank_d1_to_d3", 16'(first3 - first1), 16'd8);
        chk("blank_fd_cnt", 16'(fd_cnt), 16'd2);
        chk("blank_fd_period", 16'(fd_b - fd_a), 16'd16);

        // Enable drop during digit2 SHOW.
        enable = 1'b0;
        tick();
        blank_in = 4'b0000; data = 16'h1234; dp_in = 4'b0010; enable = 1'b1;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            tick();
            if (an == 4'b1011) found = 1;
        end
        chk("wait_digit2_show", 16'(found), 16'd1);
        enable = 1'b0;
        tick();
        chk("drop_an", {12'h0, an}, 16'h000F);
        chk("drop_fd", {15'h0, frame_done}, 16'h0000);
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (frame_done || an != 4'hF) extra++;
        end
        chk("idle_quiet", 16'(extra), 16'd0);
        enable = 1'b1;
        tick();
        chk("reen_blank_an", {12'h0, an}, 16'h000F);
        tick();
        chk("reen_show_an", {12'h0, an}, 16'h000E);
        chk("reen_show_seg", {9'h0, seg}, 16'h004C);

        // Asynchronous reset mid-scan, checked before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_an", {12'h0, an}, 16'h000F);
        chk("arst_seg", {9'h0, seg}, 16'h007F);
        chk("arst_dp", {15'h0, dp}, 16'h0001);
        chk("arst_fd", {15'h0, frame_done}, 16'h0000);
        enable = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Leading zeros.
        data = 16'h0050; dp_in = 4'h0; blank_in = 4'h0; enable = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 2) begin
                chk("lz_d0_an", {12'h0, an}, 16'h000E);
                chk("lz_d0_seg", {9'h0, seg}, 16'h0001);
            end
            if (k == 6) begin
                chk("lz_d1_an", {12'h0, an}, 16'h000D);
                chk("lz_d1_seg", {9'h0, seg}, 16'h0024);
            end
`ifdef SEG_LZ_SUPPRESS_EN
            if (k == 10) chk("lz_d2_an", {12'h0, an}, 16'h000F);
            if (k == 14) begin
                chk("lz_d3_an", {12'h0, an}, 16'h000F);
                chk("lz_d3_seg", {9'h0, seg}, 16'h007F);
            end
`else
            if (k == 10) chk("lz_d2_an", {12'h0, an}, 16'h000B);
            if (k == 14) begin
                chk("lz_d3_an", {12'h0, an}, 16'h0007);
                chk("lz_d3_seg", {9'h0, seg}, 16'h0001);
            end
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
